// File: rtl/jt900h_memwait_if.sv
// Core-side RAM port and external memory req/ack port of the wait-state bridge.
// master: the environment (core + memory), slave: the bridge itself.
interface jt900h_memwait_if;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [1:0]  cpu_we;
  logic [15:0] cpu_dout;
  logic        cpu_cen;
  logic        mem_req;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_we;
  logic [15:0] mem_dout;
  logic        mem_ack;

  modport master (
    output cpu_addr, cpu_din, cpu_we, mem_dout, mem_ack,
    input  cpu_dout, cpu_cen, mem_req, mem_addr, mem_din, mem_we
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, mem_dout, mem_ack,
    output cpu_dout, cpu_cen, mem_req, mem_addr, mem_din, mem_we
  );
endinterface

// File: rtl/jt900h_memwait.sv
// Wait-state bridge: gates the core's cen until read data or write completion
// is available from a slow req/ack memory. A one-entry read tag lets repeated
// reads of the same word proceed without a memory access. Every access is
// bounded by a timeout that returns 0xFFFF and raises a sticky bus_err.
module jt900h_memwait #(
  parameter int TOUT = 255,
  parameter int TW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  jt900h_memwait_if.slave  bus,
  input  logic             err_clr,
  output logic             bus_err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [TW-1:0] TLAST = TW'(TOUT - 1);

  logic [1:0]    st_q,   st_d;
  logic          tagv_q, tagv_d;
  logic          cen_q,  cen_d;
  logic          req_q,  req_d;
  logic [22:0]   addr_q, addr_d;
  logic [15:0]   din_q,  din_d;
  logic [1:0]    we_q,   we_d;
  logic [15:0]   dout_q, dout_d;
  logic [TW-1:0] cnt_q,  cnt_d;
  logic          err_q,  err_d;
  logic          hit;

  // Byte address bit 0 is irrelevant: the bridge always returns a full word.
  logic unused_addr0;
  assign unused_addr0 = bus.cpu_addr[0];

  // The tag address is mem_addr itself: it only changes on a miss, and a miss
  // always invalidates the tag first, so a valid tag always matches addr_q.
  assign hit = (st_q == IDLE) && (bus.cpu_we == 2'b00) && tagv_q &&
               (bus.cpu_addr[23:1] == addr_q);

  // Next-state logic for the access sequencer and the sticky error flag
  always_comb begin
    st_d   = st_q;
    tagv_d = tagv_q;
    cen_d  = 1'b0;
    req_d  = req_q;
    addr_d = addr_q;
    din_d  = din_q;
    we_d   = we_q;
    dout_d = dout_q;
    cnt_d  = cnt_q;
    err_d  = err_clr ? 1'b0 : err_q;
    case (st_q)
      IDLE: begin
        if (!hit) begin
          addr_d = bus.cpu_addr[23:1];
          din_d  = bus.cpu_din;
          we_d   = bus.cpu_we;
          tagv_d = 1'b0;
          cnt_d  = '0;
          req_d  = 1'b1;
          st_d   = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // ack takes priority over a timeout landing in the same cycle
        if (bus.mem_ack) begin
          if (we_q == 2'b00) begin
            dout_d = bus.mem_dout;
            tagv_d = 1'b1;
          end
          req_d = 1'b0;
          cen_d = 1'b1;
          st_d  = DONE;
        end else if (cnt_q == TLAST) begin
          dout_d = 16'hFFFF;
          err_d  = 1'b1;
          tagv_d = 1'b0;
          req_d  = 1'b0;
          cen_d  = 1'b1;
          st_d   = DONE;
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // State registers; reset drops an in-flight request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      tagv_q <= 1'b0;
      cen_q  <= 1'b0;
      req_q  <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      tagv_q <= tagv_d;
      cen_q  <= cen_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      we_q   <= we_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.cpu_cen  = cen_q | hit;
  assign bus.cpu_dout = dout_q;
  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_din  = din_q;
  assign bus.mem_we   = we_q;
  assign bus_err      = err_q;
endmodule

// File: tb/tb_jt900h_memwait.sv
// Bench for jt900h_memwait: directed scenarios plus a randomized access stream
// checked against a transaction-level model (word memory, one-entry tag,
// expected latency derived from the ack delay).
module tb_jt900h_memwait;
  localparam int TOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_clr = 1'b0;
  logic bus_err;
  int   errors = 0;
  int   checks = 0;

  jt900h_memwait_if bus ();

  jt900h_memwait #(.TOUT(TOUT), .TW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_clr (err_clr),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  // model state
  logic [15:0] mem_model [logic [22:0]];
  logic        m_tagv;
  logic [22:0] m_tag;
  logic [15:0] m_dout;
  logic        m_err;

  function automatic logic [15:0] rd_word(input logic [22:0] wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    return {wa[7:0], ~wa[7:0]};
  endfunction

  task automatic model_reset();
    m_tagv = 1'b0; m_tag = '0; m_dout = '0; m_err = 1'b0;
  endtask

  // One core access starting with the bridge in IDLE, called at posedge+1.
  // dly = number of REQ cycles before the memory acks (>= TOUT: never acks).
  task automatic access(input logic [23:0] a, input logic [1:0] we,
                        input logic [15:0] din, input int dly, input string nm);
    logic [22:0] wa;
    logic hit, tmo, done, obs_err;
    logic [15:0] obs_dout, exp_dout;
    int n, rq, exp_n, exp_rq;
    logic exp_err;
    wa  = a[23:1];
    hit = (we == 2'b00) && m_tagv && (m_tag == wa);
    tmo = !hit && (dly >= TOUT);
    exp_n  = hit ? 0 : (tmo ? TOUT + 1 : dly + 2);
    exp_rq = hit ? 0 : (tmo ? TOUT : dly + 1);
    if (tmo) exp_dout = 16'hFFFF;
    else if (!hit && we == 2'b00) exp_dout = rd_word(wa);
    else exp_dout = m_dout;
    exp_err = tmo ? 1'b1 : (hit ? m_err : (err_clr ? 1'b0 : m_err));
    bus.cpu_addr = a; bus.cpu_we = we; bus.cpu_din = din;
    n = 0; rq = 0; done = 1'b0; obs_dout = '0; obs_err = 1'b0;
    while (!done && n < 40) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        checks++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_din} !== {wa, we, din}) begin
          errors++;
          $display("FAIL %s mem_bus got %h/%h/%h exp %h/%h/%h", nm,
                   bus.mem_addr, bus.mem_we, bus.mem_din, wa, we, din);
        end
        if (rq == dly) begin
          bus.mem_ack  = 1'b1;
          bus.mem_dout = (we == 2'b00) ? rd_word(wa) : 16'($urandom);
          if (we[0]) mem_model[wa] = {rd_word(wa)[15:8], din[7:0]};
          if (we[1]) mem_model[wa] = {din[15:8], rd_word(wa)[7:0]};
        end
        rq++;
      end
      @(negedge clk);
      if (bus.cpu_cen) begin
        done = 1'b1; obs_dout = bus.cpu_dout; obs_err = bus_err;
      end
      @(posedge clk); #1;
      if (!done) n++;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if (!done) begin
      errors++; $display("FAIL %s cen_timeout got no cen exp cen within 40", nm);
    end else begin
      checks += 3;
      if (n != exp_n) begin
        errors++; $display("FAIL %s latency got %0d exp %0d", nm, n, exp_n);
      end
      if (rq != exp_rq) begin
        errors++; $display("FAIL %s req_cycles got %0d exp %0d", nm, rq, exp_rq);
      end
      if (obs_dout !== exp_dout) begin
        errors++; $display("FAIL %s cpu_dout got %h exp %h", nm, obs_dout, exp_dout);
      end
      if (obs_err !== exp_err) begin
        errors++; $display("FAIL %s bus_err got %b exp %b", nm, obs_err, exp_err);
      end
    end
    if (!hit) begin
      m_tagv = 1'b0;
      if (tmo) m_dout = 16'hFFFF;
      else if (we == 2'b00) begin
        m_dout = rd_word(wa); m_tagv = 1'b1; m_tag = wa;
      end
    end
    m_err = err_clr ? 1'b0 : (tmo ? 1'b1 : m_err);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cpu_addr = 24'h001234; bus.cpu_we = 2'b00; bus.cpu_din = 16'h0;
    bus.mem_ack = 1'b0; bus.mem_dout = 16'h0;
    model_reset();
    repeat (3) @(negedge clk);
    checks += 7;
    if (bus.cpu_cen !== 1'b0) begin errors++; $display("FAIL reset cpu_cen got %b exp 0", bus.cpu_cen); end
    if (bus.cpu_dout !== 16'h0) begin errors++; $display("FAIL reset cpu_dout got %h exp 0", bus.cpu_dout); end
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req got %b exp 0", bus.mem_req); end
    if (bus.mem_addr !== 23'h0) begin errors++; $display("FAIL reset mem_addr got %h exp 0", bus.mem_addr); end
    if (bus.mem_din !== 16'h0) begin errors++; $display("FAIL reset mem_din got %h exp 0", bus.mem_din); end
    if (bus.mem_we !== 2'b00) begin errors++; $display("FAIL reset mem_we got %b exp 0", bus.mem_we); end
    if (bus_err !== 1'b0) begin errors++; $display("FAIL reset bus_err got %b exp 0", bus_err); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_read_hit();
    mem_model[23'h00091A] = 16'hBEEF;
    access(24'h001234, 2'b00, 16'h0, 2, "read_miss");
    for (int i = 0; i < 5; i++) access(24'h001235, 2'b00, 16'h0, 0, "read_hit");
  endtask

  task automatic test_write();
    access(24'h000010, 2'b01, 16'h00AA, 0, "write");
    checks++;
    if (mem_model[23'h000008] !== {8'h08, 8'hAA}) begin
      errors++; $display("FAIL write_merge got %h exp 08aa", mem_model[23'h000008]);
    end
    access(24'h000010, 2'b00, 16'h0, 1, "read_after_write");
  endtask

  task automatic test_timeout();
    access(24'h003000, 2'b00, 16'h0, 99, "timeout");
    access(24'h002000, 2'b00, 16'h0, 0, "after_timeout");
    err_clr = 1'b1;
    access(24'h002000, 2'b00, 16'h0, 0, "hit_with_clr");
    checks++;
    if (bus_err !== 1'b0) begin errors++; $display("FAIL err_clr bus_err got %b exp 0", bus_err); end
    err_clr = 1'b0;
    access(24'h003002, 2'b00, 16'h0, TOUT - 1, "ack_at_timeout");
    err_clr = 1'b1;
    access(24'h003004, 2'b11, 16'h1234, 99, "set_wins_clear");
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.cpu_addr = 24'h000100; bus.cpu_we = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstmid req_before got %b exp 1", bus.mem_req); end
    rst = 1'b0; #1;
    checks += 2;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rstmid mem_req got %b exp 0", bus.mem_req); end
    if (bus.cpu_cen !== 1'b0) begin errors++; $display("FAIL rstmid cpu_cen got %b exp 0", bus.cpu_cen); end
    @(posedge clk); #1;
    rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_dout = 16'h5555;
    @(negedge clk);
    checks++;
    if (bus.cpu_cen !== 1'b0) begin errors++; $display("FAIL rstmid cen_on_ack got %b exp 0", bus.cpu_cen); end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.cpu_dout !== 16'h0) begin errors++; $display("FAIL rstmid cpu_dout got %h exp 0", bus.cpu_dout); end
    if (bus.cpu_cen !== 1'b0) begin errors++; $display("FAIL rstmid cen_after got %b exp 0", bus.cpu_cen); end
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [1:0]  we;
    int dly;
    a = 24'h400000;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(9) >= 3) a = 24'h400000 | 24'($urandom_range(7) << 1) | 24'($urandom_range(1));
      we  = ($urandom_range(9) < 6) ? 2'b00 : 2'($urandom_range(3, 1));
      dly = ($urandom_range(9) == 0) ? 7 : $urandom_range(TOUT - 1);
      err_clr = ($urandom_range(7) == 0);
      access(a, we, 16'($urandom), dly, "random");
    end
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_hit();
    test_write();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jt900h_memwait.md
Name: jt900h_memwait

Overview:
- Wait-state memory bridge between the jt900h core's RAM port (ram_addr/ram_din/ram_we/ram_dout) and a slower external memory that uses a req/ack handshake.
- Drives the core's cen, so the core only advances when read data for its current address is valid, or when its write has completed.
- Holds a one-entry read tag, so repeated cycles on an unchanged read address need no new memory access.
- Bounds every access with a timeout.

Parameters:
TOUT, 255, max cycles spent in REQ waiting for mem_ack before aborting (1..2^TW-1)
TW, 8, width of timeout counter

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
cpu_addr  input  24  byte address from core (ram_addr)
cpu_din  input  16  write data from core (ram_din)
cpu_we  input  2  byte write enables from core (ram_we); 0 = read
cpu_dout  output  16  read data to core (ram_dout)
cpu_cen  output  1  clock enable to core
mem_req  output  1  access request, level, held until ack or timeout
mem_addr  output  23  word address (cpu_addr[23:1] latched)
mem_din  output  16  latched write data
mem_we  output  2  latched byte enables
mem_dout  input  16  read data from memory, sampled with mem_ack
mem_ack  input  1  access done; one-cycle pulse, honoured only in REQ
err_clr  input  1  clears bus_err
bus_err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, tag invalid, cpu_cen=0, cpu_dout=0, mem_req=0, mem_addr=0, mem_din=0, mem_we=0, bus_err=0, counter=0.
  - Reset asserted mid-access drops mem_req at once; a later ack is ignored.
- Tag: {addr[23:1]} plus a valid bit. Set only by a completed read. Cleared by any write start, timeout, or reset.
- IDLE:
  - Hit: cpu_we==0, tag valid, cpu_addr[23:1]==tag. Then cpu_cen=1 this cycle and state stays IDLE. Continuous hits give cen every cycle.
  - Otherwise: cpu_cen=0; latch cpu_addr[23:1], cpu_din, cpu_we into mem_addr/mem_din/mem_we; invalidate tag; counter=0; go REQ.
- REQ:
  - mem_req=1; mem_addr/din/we stay stable; cpu_cen=0; counter increments each cycle.
  - mem_ack=1: for a read (mem_we==0), cpu_dout<=mem_dout and tag valid. For a write, cpu_dout is unchanged. mem_req goes 0 next cycle; go DONE.
  - counter==TOUT-1 and no ack: cpu_dout<=16'hFFFF, bus_err<=1, tag invalid, mem_req goes 0 next cycle; go DONE.
  - Ack arriving in the same cycle as the timeout condition: ack wins, no error.
- DONE:
  - cpu_cen=1 for exactly one cycle; mem_req=0; go IDLE.
  - A mem_ack seen outside REQ is ignored.
- Minimum latency on a miss: 3 cycles from address change to cen (IDLE, REQ with ack, DONE).
- Writes are never tag hits. If the core keeps the same write asserted after its cen pulse, the write is re-issued; this is idempotent by design.
- cpu_addr[0] is not used; cpu_dout is always the full word.
- bus_err:
  - Set on timeout; cleared by err_clr=1 at the next clk.
  - Set wins over clear in the same cycle.
  - Does not block later accesses.
- cpu_cen, mem_req and cpu_dout are registered outputs (no combinational path from mem_ack). The exception is the IDLE hit decision, which is combinational on cpu_addr/cpu_we against the registered tag.

Test Plan:
- Reset → all outputs 0. Read 0x001234 with ack 2 cycles after req, mem_dout=0xBEEF → mem_addr=0x00091A, cpu_dout=0xBEEF, exactly one cen pulse in DONE, tag valid.
- Hold cpu_addr=0x001235 after that read → cen=1 every cycle, mem_req stays 0 (hit, addr[0] ignored).
- Write cpu_we=2'b01, cpu_din=0x00AA to 0x000010, zero-wait ack → mem_req for 1 cycle, mem_we=01, mem_din=0x00AA, cen pulse 3 cycles after the address change, tag invalid. A following read of 0x000010 misses.
- Never ack with TOUT=4 → mem_req high for 4 cycles, then cpu_dout=0xFFFF, bus_err=1, one cen pulse. err_clr=1 → bus_err=0 next cycle.
- mem_ack in the same cycle as the timeout → data from mem_dout, bus_err stays 0.
- Assert rst during REQ, release, then pulse mem_ack → mem_req=0 immediately, ack ignored, state IDLE, no cen.
